// File: rtl/jtag_er2_writer.sv
// Host-to-fabric write port on GW_JTAG ER2: oversamples the JTAG strobes, shifts in a DATA_W-bit word LSB-first, checks its length and presents it on valid/ready.
// Optional feature macro: JTAG_ER2_READBACK_EN (capture loads the last committed word so the host reads it back on TDO).
module jtag_er2_writer #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tck_i,
  input  logic              tdi_i,
  input  logic              enable_er2_i,
  input  logic              shift_dr_capture_dr_i,
  input  logic              update_dr_i,
  output logic              tdo_er2_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              overflow_o,
  output logic              len_err_o
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  localparam int B_TCK = 0;
  localparam int B_TDI = 1;
  localparam int B_EN  = 2;
  localparam int B_SDR = 3;
  localparam int B_UPD = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT
  } state_t;

  logic [4:0]        r_sync [SYNC_STAGES];
  logic              r_tckPrev;
  logic              r_enPrev;
  logic              r_sdrPrev;
  logic              r_updPrev;
  logic              r_tckRise;
  logic              r_tckFall;
  logic              r_tdi;
  logic              r_active;
  logic              r_activeRise;
  logic              r_updRise;
  state_t            r_state;
  state_t            w_stateNext;
  logic              w_load;
  logic              w_shift;
  logic [DATA_W-1:0] w_loadVal;
  logic [DATA_W-1:0] r_dr;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [4:0]        w_synced;
  logic              w_active;
  logic              w_activePrev;

  assign w_synced     = r_sync[SYNC_STAGES-1];
  assign w_active     = w_synced[B_EN] & w_synced[B_SDR];
  assign w_activePrev = r_enPrev & r_sdrPrev;

  // Synchronizer chain, one extra stage for edge detection, then a registered event stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_tckPrev    <= 1'b0;
      r_enPrev     <= 1'b0;
      r_sdrPrev    <= 1'b0;
      r_updPrev    <= 1'b0;
      r_tckRise    <= 1'b0;
      r_tckFall    <= 1'b0;
      r_tdi        <= 1'b0;
      r_active     <= 1'b0;
      r_activeRise <= 1'b0;
      r_updRise    <= 1'b0;
    end else begin
      r_sync[0] <= {update_dr_i, shift_dr_capture_dr_i, enable_er2_i, tdi_i, tck_i};
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_tckPrev    <= w_synced[B_TCK];
      r_enPrev     <= w_synced[B_EN];
      r_sdrPrev    <= w_synced[B_SDR];
      r_updPrev    <= w_synced[B_UPD];
      r_tckRise    <= w_synced[B_EN] & w_synced[B_TCK] & ~r_tckPrev;
      r_tckFall    <= w_synced[B_EN] & ~w_synced[B_TCK] & r_tckPrev;
      r_tdi        <= w_synced[B_TDI];
      r_active     <= w_active;
      r_activeRise <= w_active & ~w_activePrev;
      r_updRise    <= w_synced[B_EN] & w_synced[B_UPD] & ~r_updPrev;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_activeRise) begin
          w_load      = 1'b1;
          w_stateNext = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // The first TCK rise here is the Capture-DR clock and shifts nothing.
        if (!r_active)      w_stateNext = S_IDLE;
        else if (r_tckRise) w_stateNext = S_SHIFT;
      end
      S_SHIFT: begin
        if (!r_active) w_stateNext = S_IDLE;
        else           w_shift = r_tckRise;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

`ifdef JTAG_ER2_READBACK_EN
  assign w_loadVal = data_o;
`else
  assign w_loadVal = '0;
`endif

  // Update is evaluated after the handshake so a coincident update overrides the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dr         <= '0;
      r_bitCnt     <= '0;
      tdo_er2_o    <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
      len_err_o    <= 1'b0;
    end else begin
      if (w_load) begin
        r_dr     <= w_loadVal;
        r_bitCnt <= '0;
      end else if (w_shift) begin
        r_dr <= {r_tdi, r_dr[DATA_W-1:1]};
        if (r_bitCnt != CNT_SAT) r_bitCnt <= r_bitCnt + 1'b1;
      end
      if (r_tckFall) tdo_er2_o <= r_dr[0];
      if (data_valid_o && data_ready_i) data_valid_o <= 1'b0;
      if (r_updRise) begin
        r_bitCnt <= '0;
        if (r_bitCnt != CNT_FULL) begin
          len_err_o <= 1'b1;
        end else if (data_valid_o && !data_ready_i) begin
          overflow_o <= 1'b1;
        end else begin
          data_o       <= r_dr;
          data_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_er2_writer.sv
// Self-checking bench for jtag_er2_writer: transaction-level model plus directed and randomized JTAG writes.
// Honours JTAG_ER2_READBACK_EN for the expected TDO stream.
module tb_jtag_er2_writer;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tck = 1'b0;
  logic         tdi = 1'b0;
  logic         en = 1'b0;
  logic         sdr = 1'b0;
  logic         upd = 1'b0;
  logic         ready = 1'b0;
  logic         tdo;
  logic [W-1:0] dataO;
  logic         validO;
  logic         ovfO;
  logic         lenO;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Transaction-level model of the visible outputs.
  logic [W-1:0] mData = '0;
  bit           mValid = 1'b0;
  bit           mOvf = 1'b0;
  bit           mLen = 1'b0;

  jtag_er2_writer #(.DATA_W(W), .SYNC_STAGES(S)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .tck_i                 (tck),
    .tdi_i                 (tdi),
    .enable_er2_i          (en),
    .shift_dr_capture_dr_i (sdr),
    .update_dr_i           (upd),
    .tdo_er2_o             (tdo),
    .data_o                (dataO),
    .data_valid_o          (validO),
    .data_ready_i          (ready),
    .overflow_o            (ovfO),
    .len_err_o             (lenO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("data_o", dataO, mData);
      checkOutput("data_valid_o", validO, mValid);
      checkOutput("overflow_o", ovfO, mOvf);
      checkOutput("len_err_o", lenO, mLen);
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_data"}, dataO, 0);
    checkOutput({tag, "_valid"}, validO, 0);
    checkOutput({tag, "_ovf"}, ovfO, 0);
    checkOutput({tag, "_len"}, lenO, 0);
    checkOutput({tag, "_tdo"}, tdo, 0);
  endtask

  task automatic tckPulse(input bit b);
    tdi = b;
    waitClk(8);
    tck = 1'b1;
    waitClk(8);
    tck = 1'b0;
  endtask

  // One host DR write: capture, len shifts, exit, update. Samples TDO before every shift rise.
  task automatic applyStimulus(input logic [63:0] bits, input int len, input bit enab,
                               input bit coincide, output int latency, output logic [63:0] tdoStream);
    logic [W-1:0] readback;
    bit           wasValid;
    bit           expTdo;
`ifdef JTAG_ER2_READBACK_EN
    readback = mData;
`else
    readback = '0;
`endif
    wasValid  = mValid;
    tdoStream = '0;
    en = enab;
    waitClk(4);
    sdr = 1'b1;
    waitClk(8);
    tckPulse(1'b0);
    for (int i = 0; i < len; i++) begin
      expTdo = (i < W) ? readback[i] : bits[i-W];
      tdi = bits[i];
      waitClk(8);
      tdoStream[i] = tdo;
      if (enab) checkOutput("tdo_bit", tdo, expTdo);
      tck = 1'b1;
      waitClk(8);
      tck = 1'b0;
    end
    waitClk(8);
    sdr = 1'b0;
    waitClk(8);
    checkEn = 1'b0;
    upd = 1'b1;
    latency = -1;
    for (int c = 1; c <= S + 6; c++) begin
      waitClk(1);
      if (c == 4) upd = 1'b0;
      if (coincide) ready = (c == S + 1);
      if (latency < 0 && validO && !wasValid) latency = c;
    end
    ready = 1'b0;
    if (enab && len != W) mLen = 1'b1;
    else if (enab && mValid && !coincide) mOvf = 1'b1;
    if (enab && len == W && (!mValid || coincide)) begin
      mData  = bits[W-1:0];
      mValid = 1'b1;
    end else if (coincide && mValid) begin
      mValid = 1'b0;
    end
    checkEn = 1'b1;
  endtask

  task automatic consume();
    ready = 1'b1;
    waitClk(1);
    ready  = 1'b0;
    mValid = 1'b0;
    checkOutput("valid_after_ready", validO, 0);
    waitClk(2);
  endtask

  initial begin
    int           lat;
    logic [63:0]  st;
    logic [63:0]  rb;
    int           len;
    bit           enab;
    bit           coin;

    rst = 1'b1;
    waitClk(3);
    checkResetValues("reset");
    rst = 1'b0;
    checkEn = 1'b1;
    waitClk(4);

    applyStimulus(64'hDEADBEEF, W, 1'b1, 1'b0, lat, st);
    checkOutput("commit_latency", lat, S + 2);
    checkOutput("data_deadbeef", dataO, 32'hDEADBEEF);
    checkOutput("valid_deadbeef", validO, 1);
    consume();

    applyStimulus(64'h12345678, W, 1'b1, 1'b0, lat, st);
`ifdef JTAG_ER2_READBACK_EN
    checkOutput("tdo_readback", st[W-1:0], 32'hDEADBEEF);
`else
    checkOutput("tdo_zeros", st[W-1:0], 0);
`endif
    checkOutput("data_12345678", dataO, 32'h12345678);
    consume();

    applyStimulus(64'hCAFEF00D, W, 1'b0, 1'b0, lat, st);
    checkOutput("disabled_data", dataO, 32'h12345678);
    checkOutput("disabled_valid", validO, 0);
    checkOutput("disabled_ovf", ovfO, 0);
    checkOutput("disabled_len", lenO, 0);
    en = 1'b1;

    applyStimulus(64'h1, W, 1'b1, 1'b0, lat, st);
    applyStimulus(64'h2, W, 1'b1, 1'b0, lat, st);
    checkOutput("ovf_set", ovfO, 1);
    checkOutput("ovf_data_kept", dataO, 32'h1);
    applyStimulus(64'h3, W, 1'b1, 1'b1, lat, st);
    checkOutput("coincide_data", dataO, 32'h3);
    checkOutput("coincide_valid", validO, 1);
    consume();

    applyStimulus(64'hAAAA5555, W - 1, 1'b1, 1'b0, lat, st);
    checkOutput("len31_err", lenO, 1);
    applyStimulus(64'h1_0F0F0F0F, W + 1, 1'b1, 1'b0, lat, st);
    checkOutput("len33_err", lenO, 1);
    checkOutput("len_valid", validO, 0);
    checkOutput("len_data_kept", dataO, 32'h3);
`ifdef JTAG_ER2_READBACK_EN
    rb = 64'h0F0F0F0F_00000003;
    checkOutput("tdo_len33", st[W:0], rb[W:0]);
`endif

    for (int it = 0; it < 30; it++) begin
      len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(28, 36)) : W;
      enab = ($urandom_range(0, 9) != 0);
      coin = ($urandom_range(0, 3) == 0);
      applyStimulus({$urandom(), $urandom()}, len, enab, coin, lat, st);
      en = 1'b1;
      if ($urandom_range(0, 1) == 1) consume();
    end

    en = 1'b1;
    waitClk(4);
    sdr = 1'b1;
    waitClk(8);
    tckPulse(1'b0);
    for (int i = 0; i < 16; i++) tckPulse(1'($urandom_range(0, 1)));
    checkEn = 1'b0;
    rst = 1'b1;
    waitClk(2);
    checkResetValues("midshift_reset");
    rst = 1'b0;
    mData = '0;
    mValid = 1'b0;
    mOvf = 1'b0;
    mLen = 1'b0;
    checkEn = 1'b1;
    waitClk(8);
    sdr = 1'b0;
    waitClk(8);
    checkEn = 1'b0;
    upd = 1'b1;
    waitClk(4);
    upd = 1'b0;
    waitClk(S + 2);
    mLen = 1'b1;
    checkEn = 1'b1;
    checkOutput("len_err_after_reset", lenO, 1);
    checkOutput("valid_after_reset", validO, 0);
    waitClk(4);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
